// File: rtl/sr_latch_sequencer_pkg.sv
// rtl/sr_latch_sequencer_pkg.sv - shared types and helpers for the SR latch sequencer
package sr_latch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    localparam logic TGT_SET = 1'b1;
    localparam logic TGT_CLR = 1'b0;

    // Wide enough for the largest reload value of the shared timer.
    function automatic int cnt_width(input int pulse_w, input int gap_w, input int timeout);
        int m;
        m = pulse_w;
        if (gap_w > m) m = gap_w;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_latch_sequencer_if.sv
// rtl/sr_latch_sequencer_if.sv - request/ack, latch drive and status bundle
interface sr_latch_sequencer_if;
    logic set_req;
    logic clr_req;
    logic q_in;
    logic set_ack;
    logic clr_ack;
    logic s_out;
    logic r_out;
    logic busy;
    logic done;
    logic err;

    modport master (
        output set_req, clr_req, q_in,
        input  set_ack, clr_ack, s_out, r_out, busy, done, err
    );

    modport slave (
        input  set_req, clr_req, q_in,
        output set_ack, clr_ack, s_out, r_out, busy, done, err
    );
endinterface

// File: rtl/sr_latch_sequencer_timer.sv
// rtl/sr_latch_sequencer_timer.sv - loadable down-counter with zero flag
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/sr_latch_sequencer.sv
// rtl/sr_latch_sequencer.sv - SR latch set/clear sequencer with arbitration and feedback check
module sr_latch_sequencer
    import sr_latch_sequencer_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_latch_sequencer_if.slave  bus
);
    localparam int CW = cnt_width(PULSE_W, GAP_W, TIMEOUT);

    seq_state_e    state, state_d;
    logic          target, target_d;
    logic          last_grant, last_grant_d;
    logic          grant, grant_tgt;
    logic          tmr_load, tmr_zero;
    logic [CW-1:0] tmr_val;
    logic          set_ack_q, clr_ack_q, s_q, r_q, busy_q, done_q, err_q;
    logic          set_ack_d, clr_ack_d, s_d, r_d, busy_d, done_d, err_d;

    seq_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // On a tie the side that was not served last wins.
    always_comb begin
        grant     = bus.set_req | bus.clr_req;
        grant_tgt = TGT_CLR;
        if (bus.set_req && bus.clr_req) grant_tgt = ~last_grant;
        else if (bus.set_req)           grant_tgt = TGT_SET;
    end

    always_comb begin
        state_d      = state;
        target_d     = target;
        last_grant_d = last_grant;
        unique case (state)
            ST_IDLE: begin
                if (grant) begin
                    target_d     = grant_tgt;
                    last_grant_d = grant_tgt;
                    state_d      = (bus.q_in == grant_tgt) ? ST_GAP : ST_PULSE;
                end
            end
            ST_PULSE: if (tmr_zero) state_d = ST_CHECK;
            ST_CHECK: if ((bus.q_in == target) || tmr_zero) state_d = ST_GAP;
            ST_GAP:   if (tmr_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The shared timer is reloaded on every state entry.
        tmr_load = (state_d != state);
        case (state_d)
            ST_PULSE: tmr_val = CW'(PULSE_W - 1);
            ST_CHECK: tmr_val = CW'(TIMEOUT - 1);
            ST_GAP:   tmr_val = CW'(GAP_W - 1);
            default:  tmr_val = '0;
        endcase
    end

    always_comb begin
        set_ack_d = (state == ST_IDLE) && grant && (grant_tgt == TGT_SET);
        clr_ack_d = (state == ST_IDLE) && grant && (grant_tgt == TGT_CLR);
        s_d       = (state == ST_PULSE) && (target == TGT_SET);
        r_d       = (state == ST_PULSE) && (target == TGT_CLR);
        busy_d    = (state != ST_IDLE);
        done_d    = ((state == ST_IDLE) && grant && (bus.q_in == grant_tgt)) ||
                    ((state == ST_CHECK) && (bus.q_in == target));
        err_d     = (state == ST_CHECK) && (bus.q_in != target) && tmr_zero;
    end

    // Async clear drops s_out/r_out immediately and suppresses done/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target     <= TGT_CLR;
            last_grant <= TGT_CLR;
            set_ack_q  <= 1'b0;
            clr_ack_q  <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            last_grant <= last_grant_d;
            set_ack_q  <= set_ack_d;
            clr_ack_q  <= clr_ack_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.set_ack = set_ack_q;
    assign bus.clr_ack = clr_ack_q;
    assign bus.s_out   = s_q;
    assign bus.r_out   = r_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_sr_latch_sequencer.sv
// tb/tb_sr_latch_sequencer.sv - scoreboard bench for sr_latch_sequencer with an ideal latch model
module tb_sr_latch_sequencer;
    localparam int PW = 2;
    localparam int GW = 1;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sr_latch_sequencer_if bus ();

    sr_latch_sequencer #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal latch; stuck_en disconnects it from q_in.
    logic latch_q   = 1'b0;
    logic stuck_en  = 1'b0;
    logic stuck_val = 1'b0;
    always @(posedge bus.s_out or posedge bus.r_out) latch_q = bus.s_out ? 1'b1 : 1'b0;
    assign bus.q_in = stuck_en ? stuck_val : latch_q;

    typedef struct {
        int kind;
        int at;
        int exp_s;
        int exp_r;
    } ev_t;

    ev_t   sb[$];
    string kname[4] = '{"set_ack", "clr_ack", "done", "err"};

    bit mq      = 1'b0;
    bit mlast   = 1'b0;
    int free_at = 0;
    int s_cnt   = 0;
    int r_cnt   = 0;

    task automatic check_event(input int kind);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s at cycle %0d, want none", kname[kind], cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.at != cyc) begin
            bad++;
            $display("FAIL event_order: got %s@%0d, want %s@%0d", kname[kind], cyc, kname[e.kind], e.at);
        end
        if (kind >= 2) begin
            total++;
            if (s_cnt != e.exp_s || r_cnt != e.exp_r) begin
                bad++;
                $display("FAIL pulse_width: got s=%0d r=%0d, want s=%0d r=%0d", s_cnt, r_cnt, e.exp_s, e.exp_r);
            end
            s_cnt = 0;
            r_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            s_cnt = 0;
            r_cnt = 0;
        end
        total++;
        if (bus.s_out && bus.r_out) begin
            bad++;
            $display("FAIL sr_overlap: got s=1 r=1 at cycle %0d, want never both", cyc);
        end
        total++;
        if (bus.done && bus.err) begin
            bad++;
            $display("FAIL done_err_together: got both at cycle %0d, want exclusive", cyc);
        end
        if (bus.s_out) s_cnt++;
        if (bus.r_out) r_cnt++;
        if (bus.set_ack) check_event(0);
        if (bus.clr_ack) check_event(1);
        if (bus.done)    check_event(2);
        if (bus.err)     check_event(3);
    end

    // Transaction-level reference: one grant, its outcome, and when the sequencer frees up.
    task automatic model_grant(input bit tgt, input int a);
        bit qv;
        int pulse_s;
        int pulse_r;
        sb.push_back('{tgt ? 0 : 1, a, 0, 0});
        qv      = stuck_en ? stuck_val : mq;
        pulse_s = tgt ? PW : 0;
        pulse_r = tgt ? 0 : PW;
        if (qv == tgt) begin
            sb.push_back('{2, a, 0, 0});
            free_at = a + GW + 1;
        end else begin
            mq = tgt;
            if (stuck_en) begin
                sb.push_back('{3, a + PW + TO, pulse_s, pulse_r});
                free_at = a + PW + TO + GW + 1;
            end else begin
                sb.push_back('{2, a + PW + 1, pulse_s, pulse_r});
                free_at = a + PW + 1 + GW + 1;
            end
        end
        mlast = tgt;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d events outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    // mode: 0 latch connected, 1 q_in stuck at 0, 2 q_in stuck at 1
    task automatic issue(input bit ds, input bit dc, input int mode);
        int a;
        bit first;
        stuck_en  = (mode != 0);
        stuck_val = (mode == 2);
        a = cyc + 1;
        if (a < free_at) a = free_at;
        first = (ds && dc) ? ~mlast : ds;
        model_grant(first, a);
        if (ds && dc) model_grant(~first, free_at);
        bus.set_req = ds;
        bus.clr_req = dc;
        for (int i = 0; i < 200 && (bus.set_req || bus.clr_req); i++) begin
            @(negedge clk);
            if (bus.set_ack) bus.set_req = 1'b0;
            if (bus.clr_ack) bus.clr_req = 1'b0;
        end
        total++;
        if (bus.set_req || bus.clr_req) begin
            bad++;
            $display("FAIL ack_wait: got req still pending set=%0b clr=%0b, want acked", bus.set_req, bus.clr_req);
            bus.set_req = 1'b0;
            bus.clr_req = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        bit ds;
        bit dc;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;

        repeat (6) begin
            @(negedge clk);
            bus.set_req = 1'($urandom_range(0, 1));
            bus.clr_req = 1'($urandom_range(0, 1));
            total++;
            if ({bus.set_ack, bus.clr_ack, bus.s_out, bus.r_out, bus.busy, bus.done, bus.err} != 7'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %07b, want 0000000",
                         {bus.set_ack, bus.clr_ack, bus.s_out, bus.r_out, bus.busy, bus.done, bus.err});
            end
        end
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_reset: got %0b, want 0", bus.busy);
        end

        issue(1, 1, 0);
        issue(1, 0, 0);
        issue(0, 1, 0);
        issue(1, 0, 0);
        issue(0, 1, 1);
        issue(1, 0, 1);
        issue(0, 1, 2);

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ds = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            if (!ds && !dc) ds = 1'b1;
            case ($urandom_range(0, 3))
                2:       issue(ds, dc, 1);
                3:       issue(ds, dc, 2);
                default: issue(ds, dc, 0);
            endcase
        end

        // Abort a clear pulse with reset mid-cycle.
        issue(1, 0, 0);
        repeat (3) @(negedge clk);
        bus.clr_req = 1'b1;
        sb.push_back('{1, cyc + 1, 0, 0});
        @(negedge clk);
        bus.clr_req = 1'b0;
        @(posedge clk);
        #2;
        total++;
        if (bus.r_out !== 1'b1) begin
            bad++;
            $display("FAIL r_before_reset: got %0b, want 1", bus.r_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.r_out !== 1'b0) begin
            bad++;
            $display("FAIL r_async_drop: got %0b, want 0", bus.r_out);
        end
        mq      = 1'b0;
        mlast   = 1'b0;
        free_at = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (bus.busy || bus.done || bus.err) begin
                bad++;
                $display("FAIL post_abort_idle: got busy=%0b done=%0b err=%0b, want 0 0 0",
                         bus.busy, bus.done, bus.err);
            end
        end
        issue(0, 1, 0);
        issue(1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, want earlier finish");
        $fatal(1);
    end
endmodule
